// File: rtl/card_pkg.sv
`default_nettype none
//==========================================================================
// card_pkg -- shared rank type, deck constants and shoe FSM encoding. Rev 1.0
//==========================================================================
package card_pkg;

    typedef logic [3:0] rank_t;

    localparam rank_t RANK_MIN       = 4'd1;
    localparam rank_t RANK_MAX       = 4'd13;
    localparam int    NUM_RANKS      = 13;
    localparam int    CARDS_PER_RANK = 4;
    localparam int    DECK_SIZE      = 52;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_SEARCH = 2'd2
    } shoe_state_t;

    function automatic rank_t next_rank(input rank_t r);
        return (r == RANK_MAX) ? RANK_MIN : rank_t'(r + 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_shoe_if.sv
`default_nettype none
//==========================================================================
// card_shoe_if -- request/status bundle between a dealer and the shoe. Rev 1.0
//==========================================================================
interface card_shoe_if;
    import card_pkg::*;

    logic        deal_req;
    logic        reshuffle;
    rank_t       new_card;
    logic        card_valid;
    logic        busy;
    logic [8:0]  cards_left;
    logic        shoe_empty;

    modport master (
        output deal_req,
        output reshuffle,
        input  new_card,
        input  card_valid,
        input  busy,
        input  cards_left,
        input  shoe_empty
    );

    modport slave (
        input  deal_req,
        input  reshuffle,
        output new_card,
        output card_valid,
        output busy,
        output cards_left,
        output shoe_empty
    );
endinterface
`default_nettype wire

// File: rtl/rank_counter.sv
`default_nettype none
//==========================================================================
// rank_counter -- wrapping 1..13 rank counter with enable. Rev 1.0
//==========================================================================
module rank_counter
    import card_pkg::*;
(
    input  logic  fast_clock,
    input  logic  resetb,
    input  logic  enable,
    output rank_t rank
);

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            rank <= RANK_MIN;
        end else if (enable) begin
            rank <= next_rank(rank);
        end
    end

endmodule
`default_nettype wire

// File: rtl/card_shoe.sv
`default_nettype none
//==========================================================================
// card_shoe -- multi-deck card shoe dealing pseudo-random ranks. Rev 1.0
//==========================================================================
module card_shoe
    import card_pkg::*;
#(
    parameter int NUM_DECKS = 1
) (
    input  logic         fast_clock,
    input  logic         resetb,
    card_shoe_if.slave   bus
);

    localparam logic [5:0] FULL_COUNT = 6'(CARDS_PER_RANK * NUM_DECKS);
    localparam logic [8:0] FULL_SHOE  = 9'(DECK_SIZE * NUM_DECKS);

    shoe_state_t state;
    shoe_state_t state_next;

    rank_t       rank_ctr;
    rank_t       probe;
    rank_t       new_card;
    logic        card_valid;
    logic        deal_pending;
    logic        pending_next;
    logic [8:0]  cards_left;
    logic [RANK_MAX:RANK_MIN][5:0] counts;

    logic        probe_hit;
    logic        load_probe;
    logic        step_probe;
    logic        do_refill;
    logic        take_card;

    rank_counter u_rank_counter (
        .fast_clock (fast_clock),
        .resetb     (resetb),
        .enable     (1'b1),
        .rank       (rank_ctr)
    );

    assign probe_hit = (counts[probe] != 6'd0);

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = deal_pending;
        load_probe   = 1'b0;
        step_probe   = 1'b0;
        do_refill    = 1'b0;
        take_card    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Reshuffle has priority; a simultaneous deal rides along as pending.
                if (bus.reshuffle) begin
                    state_next   = ST_REFILL;
                    pending_next = bus.deal_req;
                end else if (bus.deal_req && (cards_left == 9'd0)) begin
                    state_next   = ST_REFILL;
                    pending_next = 1'b1;
                end else if (bus.deal_req) begin
                    state_next   = ST_SEARCH;
                    load_probe   = 1'b1;
                end
            end
            ST_REFILL: begin
                do_refill    = 1'b1;
                pending_next = 1'b0;
                if (deal_pending) begin
                    state_next = ST_SEARCH;
                    load_probe = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (probe_hit) begin
                    take_card  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    step_probe = 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    // Refill and take are mutually exclusive by state, so the count updates never collide.
    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            probe        <= RANK_MIN;
            counts       <= {NUM_RANKS{FULL_COUNT}};
            cards_left   <= FULL_SHOE;
            new_card     <= '0;
            card_valid   <= 1'b0;
            deal_pending <= 1'b0;
        end else begin
            card_valid   <= take_card;
            deal_pending <= pending_next;
            if (load_probe) begin
                probe <= rank_ctr;
            end else if (step_probe) begin
                probe <= next_rank(probe);
            end
            if (do_refill) begin
                counts     <= {NUM_RANKS{FULL_COUNT}};
                cards_left <= FULL_SHOE;
            end else if (take_card) begin
                counts[probe] <= counts[probe] - 6'd1;
                cards_left    <= cards_left - 9'd1;
                new_card      <= probe;
            end
        end
    end

    assign bus.new_card   = new_card;
    assign bus.card_valid = card_valid;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.cards_left = cards_left;
    assign bus.shoe_empty = (cards_left == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
//==========================================================================
// tb_card_shoe -- self-checking bench for card_shoe against a deal model. Rev 1.0
//==========================================================================
module tb_card_shoe;
    import card_pkg::*;

    localparam int ND        = 1;
    localparam int FULL_CNT  = CARDS_PER_RANK * ND;
    localparam int FULL_SHOE = DECK_SIZE * ND;

    logic fast_clock = 1'b0;
    logic resetb     = 1'b1;

    card_shoe_if bus ();

    card_shoe #(.NUM_DECKS(ND)) dut (
        .fast_clock (fast_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 fast_clock = ~fast_clock;

    // Edges since reset release: the rank seen at the next edge is (edges % 13) + 1.
    int edges;
    always @(posedge fast_clock or negedge resetb) begin
        if (!resetb) edges <= 0;
        else         edges <= edges + 1;
    end

    int checks   = 0;
    int failures = 0;
    int mcnt [1:13];
    int mleft;
    int seen [1:13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_refill();
        for (int i = 1; i <= 13; i++) mcnt[i] = FULL_CNT;
        mleft = FULL_SHOE;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge fast_clock);
            #1;
        end
    endtask

    task automatic wait_rank(input int r);
        while (((edges % 13) + 1) != r) begin
            @(posedge fast_clock);
            #1;
        end
    endtask

    // One deal: predict rank and latency from the shoe contents, then watch the DUT.
    task automatic do_deal(input bit resh, input bit hold);
        int  r, k, lat, n;
        bit  refill, found;
        refill = resh || (mleft == 0);
        r = ((edges + (refill ? 1 : 0)) % 13) + 1;
        if (refill) model_refill();
        k = 0;
        while (mcnt[r] == 0 && k < 13) begin
            r = (r % 13) + 1;
            k++;
        end
        lat = 2 + k + (refill ? 1 : 0);
        bus.deal_req  = 1'b1;
        bus.reshuffle = resh;
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(posedge fast_clock);
            #1;
            n++;
            if (bus.card_valid) begin
                found = 1'b1;
            end else begin
                if (n < lat) chk("busy_during_deal", bus.busy, 1);
                if (refill && n == 2) chk("refill_cards_left", bus.cards_left, FULL_SHOE);
                // Requests while busy must be ignored.
                if (!hold) begin
                    bus.deal_req  = 1'($urandom);
                    bus.reshuffle = 1'($urandom);
                end else begin
                    bus.reshuffle = 1'b0;
                end
            end
        end
        if (!hold) begin
            bus.deal_req  = 1'b0;
            bus.reshuffle = 1'b0;
        end
        chk("deal_latency", n, lat);
        chk("new_card", bus.new_card, r);
        if (found && bus.new_card >= 4'd1 && bus.new_card <= 4'd13) seen[bus.new_card]++;
        mcnt[r]--;
        mleft--;
        chk("cards_left", bus.cards_left, mleft);
        chk("shoe_empty", bus.shoe_empty, (mleft == 0) ? 1 : 0);
        if (!hold) begin
            @(posedge fast_clock);
            #1;
            chk("valid_single_cycle", bus.card_valid, 0);
            chk("new_card_holds", bus.new_card, r);
        end
    endtask

    task automatic do_reshuffle();
        bus.reshuffle = 1'b1;
        @(posedge fast_clock);
        #1;
        bus.reshuffle = 1'b0;
        chk("reshuffle_busy", bus.busy, 1);
        chk("reshuffle_no_valid0", bus.card_valid, 0);
        @(posedge fast_clock);
        #1;
        model_refill();
        chk("reshuffle_idle", bus.busy, 0);
        chk("reshuffle_cards_left", bus.cards_left, mleft);
        chk("reshuffle_no_valid1", bus.card_valid, 0);
    endtask

    initial begin
        bus.deal_req  = 1'b0;
        bus.reshuffle = 1'b0;
        for (int i = 1; i <= 13; i++) seen[i] = 0;
        #1;
        resetb = 1'b0;
        #1;
        model_refill();
        chk("rst_new_card", bus.new_card, 0);
        chk("rst_card_valid", bus.card_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cards_left", bus.cards_left, FULL_SHOE);
        chk("rst_shoe_empty", bus.shoe_empty, 0);
        #10;
        resetb = 1'b1;

        // First edge after reset deals rank 1 with minimum latency.
        do_deal(1'b0, 1'b0);

        // Drain rank 1, then a fifth request must skip to rank 2.
        for (int i = 0; i < 4; i++) begin
            wait_rank(1);
            do_deal(1'b0, 1'b0);
        end

        for (int i = 0; i < 5; i++) begin
            idle($urandom_range(0, 3));
            do_deal(1'b0, 1'b0);
        end
        do_reshuffle();

        // Reshuffle and deal together.
        idle($urandom_range(0, 3));
        do_deal(1'b1, 1'b0);

        // Empty the shoe completely.
        do_reshuffle();
        for (int i = 1; i <= 13; i++) seen[i] = 0;
        for (int i = 0; i < FULL_SHOE; i++) begin
            idle($urandom_range(0, 2));
            do_deal(1'b0, 1'b0);
        end
        for (int i = 1; i <= 13; i++) chk("rank_dealt_4x", seen[i], FULL_CNT);
        chk("empty_flag", bus.shoe_empty, 1);
        chk("empty_cards_left", bus.cards_left, 0);
        do_deal(1'b0, 1'b0);

        // deal_req held high across several deals.
        idle($urandom_range(0, 3));
        for (int i = 0; i < 6; i++) do_deal(1'b0, 1'b1);
        bus.deal_req = 1'b0;
        @(posedge fast_clock);
        #1;
        chk("hold_no_back_to_back", bus.card_valid, 0);

        // Reset while searching abandons the deal.
        idle(2);
        bus.deal_req = 1'b1;
        @(posedge fast_clock);
        #1;
        bus.deal_req = 1'b0;
        chk("pre_reset_busy", bus.busy, 1);
        resetb = 1'b0;
        #1;
        model_refill();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.card_valid, 0);
        chk("midrst_new_card", bus.new_card, 0);
        chk("midrst_cards_left", bus.cards_left, FULL_SHOE);
        chk("midrst_empty", bus.shoe_empty, 0);
        idle(2);
        chk("midrst_no_valid", bus.card_valid, 0);
        @(negedge fast_clock);
        resetb = 1'b1;
        do_deal(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_shoe.md
CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 Parameter: NUM_DECKS, default 1, number of 52-card decks in the shoe (legal 1..8).
REQ-002 fast_clock  input  1  sole clock; all state updates on rising edge.
REQ-003 resetb  input  1  asynchronous, active-low reset.
REQ-004 deal_req  input  1  request one card; sampled only in IDLE.
REQ-005 reshuffle  input  1  refill shoe to full; sampled only in IDLE.
REQ-006 new_card  output  4  rank of last dealt card (1=A .. 13=K), 0 = none dealt since reset.
REQ-007 card_valid  output  1  one-cycle pulse marking a newly dealt new_card.
REQ-008 busy  output  1  high whenever FSM is not in IDLE.
REQ-009 cards_left  output  9  cards remaining in shoe.
REQ-010 shoe_empty  output  1  high exactly when cards_left == 0.

Function
REQ-011 rank_ctr shall free-run 1,2,..,13,1,... advancing every fast_clock edge regardless of FSM state.
REQ-012 Per-rank count registers (13 entries, 6 bits) shall track remaining cards; full value is 4*NUM_DECKS.
REQ-013 FSM states: IDLE, REFILL, SEARCH, with IDLE as the reset state.
REQ-014 IDLE: reshuffle=1 -> REFILL; else deal_req=1 with cards_left==0 -> REFILL; else deal_req=1 -> SEARCH with probe loaded from pre-edge rank_ctr value.
REQ-015 reshuffle and deal_req both high in IDLE -> REFILL, then SEARCH (deal pending), probe loaded from rank_ctr at REFILL exit edge.
REQ-016 REFILL shall last exactly one cycle: all counts <- 4*NUM_DECKS, cards_left <- 52*NUM_DECKS; exit to SEARCH if a deal is pending, else IDLE.
REQ-017 SEARCH, count[probe]!=0: new_card<=probe, count[probe] decremented, cards_left decremented, card_valid high the following cycle only, next state IDLE.
REQ-018 SEARCH, count[probe]==0: probe advances with wrap 13->1, remain in SEARCH; SEARCH never exceeds 13 cycles.
REQ-019 Latency: card_valid asserts minimum 2 edges after the sampling edge of deal_req, maximum 14 (15 via REFILL).
REQ-020 deal_req/reshuffle asserted while busy shall be ignored, not queued.
REQ-021 new_card shall hold its value between deals; card_valid shall never be high for two consecutive cycles.
REQ-022 cards_left shall equal the sum of the 13 counts at all times.

Reset
REQ-023 resetb low shall immediately force: state IDLE, rank_ctr=1, all counts=4*NUM_DECKS, cards_left=52*NUM_DECKS, new_card=0, card_valid=0, busy=0, shoe_empty=0.
REQ-024 Reset mid-SEARCH or mid-REFILL shall abandon the operation with no card_valid pulse.

Structure
REQ-025 Shared package card_pkg shall hold: rank typedef (4 bits), RANK_MIN=1, RANK_MAX=13, CARDS_PER_RANK=4, DECK_SIZE=52, shoe state enum.
REQ-026 One sub-module rank_counter (wrapping 1..13 counter with enable, resetb) shall be instantiated for rank_ctr; probe stepping lives in card_shoe.

Verification
REQ-027 Reset, deal_req on first edge (rank_ctr=1) -> card_valid pulse 2 edges later, new_card=1, cards_left=51.
REQ-028 Four deals each sampled with rank_ctr=1, then a fifth -> fifth yields new_card=2 after 3 edges, count[1]=0.
REQ-029 52 consecutive deals -> shoe_empty=1, cards_left=0, each rank dealt exactly 4 times; 53rd deal -> REFILL, cards_left 52 then 51, valid card.
REQ-030 Deal 10 cards, pulse reshuffle in IDLE -> one busy cycle, cards_left=52, no card_valid.
REQ-031 deal_req held high throughout SEARCH -> exactly one card_valid per IDLE entry, no back-to-back pulses.
REQ-032 Assert resetb=0 during SEARCH -> outputs immediately take reset values, no card_valid, cards_left=52.
